// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's hazard/redirect inputs, instruction RAM port
// and IF/ID pipeline register outputs.
interface if_stage_if #(
    parameter int ADDR_W = 9
);
    logic              stall;
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [31:0]       pc;
    logic [31:0]       ifid_instr;
    logic [31:0]       ifid_pc_plus4;
    logic              ifid_valid;
    logic              halted;

    // Environment side: hazard unit, branch resolver, instruction RAM, decode.
    modport master (
        output stall, branch_taken, branch_target, imem_data,
        input  imem_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, halted
    );

    // Fetch stage side.
    modport slave (
        input  stall, branch_taken, branch_target, imem_data,
        output imem_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, halted
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction RAM and fills the IF/ID register. A fetched halt word freezes
// the PC, lets the pipeline drain for DRAIN_CYCLES edges, then raises halted.
module if_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ADDR_W       = 9,
    parameter logic [31:0] HALT_WORD    = 32'hffff_ffff,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic      clk,
    input  logic      reset,
    if_stage_if.slave bus
);
    localparam int               CNT_W    = $clog2(DRAIN_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t            state_r;
    logic [31:0]       pc_r;
    logic [31:0]       ifid_instr_r;
    logic [31:0]       ifid_pc_plus4_r;
    logic              ifid_valid_r;
    logic              halted_r;
    logic [CNT_W-1:0]  drain_cnt_r;
    logic [31:0]       pc_plus4_s;
    logic [31:0]       target_s;

    // Sequential PC wraps modulo 2^32; redirect targets are forced word aligned.
    assign pc_plus4_s = pc_r + 32'd4;
    assign target_s   = bus.branch_target & 32'hffff_fffc;

    // RAM has no latency: the word address is a straight slice of the PC.
    assign bus.imem_addr     = pc_r[ADDR_W+1:2];
    assign bus.pc            = pc_r;
    assign bus.ifid_instr    = ifid_instr_r;
    assign bus.ifid_pc_plus4 = ifid_pc_plus4_r;
    assign bus.ifid_valid    = ifid_valid_r;
    assign bus.halted        = halted_r;

    // Fetch/drain/halt controller with PC and IF/ID register updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r            <= RESET_PC;
            ifid_instr_r    <= NOP_WORD;
            ifid_pc_plus4_r <= 32'd0;
            ifid_valid_r    <= 1'b0;
            halted_r        <= 1'b0;
            drain_cnt_r     <= {CNT_W{1'b0}};
            state_r         <= ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (bus.branch_taken) begin
                        // Squash the wrong-path word currently on the RAM bus.
                        pc_r         <= target_s;
                        ifid_instr_r <= NOP_WORD;
                        ifid_valid_r <= 1'b0;
                    end else if (bus.stall) begin
                        pc_r <= pc_r;
                    end else if (bus.imem_data != HALT_WORD) begin
                        ifid_instr_r    <= bus.imem_data;
                        ifid_pc_plus4_r <= pc_plus4_s;
                        ifid_valid_r    <= 1'b1;
                        pc_r            <= pc_plus4_s;
                    end else begin
                        // Halt word goes downstream; PC stops advancing.
                        ifid_instr_r    <= HALT_WORD;
                        ifid_pc_plus4_r <= pc_plus4_s;
                        ifid_valid_r    <= 1'b1;
                        drain_cnt_r     <= {CNT_W{1'b0}};
                        state_r         <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.branch_taken) begin
                        // The halt was speculative; resume fetching at the target.
                        pc_r         <= target_s;
                        ifid_instr_r <= NOP_WORD;
                        ifid_valid_r <= 1'b0;
                        drain_cnt_r  <= {CNT_W{1'b0}};
                        state_r      <= ST_FETCH;
                    end else if (bus.stall) begin
                        drain_cnt_r <= drain_cnt_r;
                    end else begin
                        ifid_instr_r <= NOP_WORD;
                        ifid_valid_r <= 1'b0;
                        if (drain_cnt_r == CNT_LAST) begin
                            halted_r <= 1'b1;
                            state_r  <= ST_HALT;
                        end else begin
                            drain_cnt_r <= drain_cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_HALT: begin
                    halted_r <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: fall back to a clean fetch with a bubble.
                    ifid_instr_r <= NOP_WORD;
                    ifid_valid_r <= 1'b0;
                    drain_cnt_r  <= {CNT_W{1'b0}};
                    state_r      <= ST_FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run,
// all compared against a behavioural fetch-pipeline model.
module tb_if_stage;
    localparam int          ADDR_W = 9;
    localparam logic [31:0] HALT   = 32'hffff_ffff;

    logic        clk;
    logic        reset;
    logic [31:0] mem [0:511];

    if_stage_if #(.ADDR_W(ADDR_W)) bus ();
    if_stage #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    assign bus.imem_data = mem[bus.imem_addr];

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid, m_halted;
    int          drain_left;

    int vectors = 0;
    int miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h1234_5678;
        return w;
    endfunction

    // PC+4 is only meaningful while the slot holds a real instruction.
    function automatic logic [136:0] dut_vec();
        return {bus.pc, bus.ifid_instr, (m_valid ? bus.ifid_pc_plus4 : 32'd0),
                bus.ifid_valid, bus.halted, bus.imem_addr};
    endfunction

    function automatic logic [136:0] mdl_vec();
        logic [31:0] p;
        p = m_pc;
        return {m_pc, m_instr, (m_valid ? m_pp4 : 32'd0), m_valid, m_halted, p[10:2]};
    endfunction

    task automatic model_step(input logic r, input logic s, input logic b, input logic [31:0] t);
        logic [31:0] w;
        w = mem[m_pc[10:2]];
        if (r) begin
            m_pc = 32'd0; m_instr = 32'd0; m_pp4 = 32'd0;
            m_valid = 1'b0; m_halted = 1'b0; drain_left = 0;
        end else if (m_halted) begin
            // frozen until reset
        end else if (b) begin
            m_pc = {t[31:2], 2'b00}; m_instr = 32'd0; m_valid = 1'b0; drain_left = 0;
        end else if (s) begin
            // hold
        end else if (drain_left > 0) begin
            m_instr = 32'd0; m_valid = 1'b0;
            drain_left = drain_left - 1;
            if (drain_left == 0) m_halted = 1'b1;
        end else if (w != HALT) begin
            m_instr = w; m_pp4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end else begin
            m_instr = HALT; m_pp4 = m_pc + 32'd4; m_valid = 1'b1; drain_left = 4;
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic b, input logic [31:0] t);
        reset = r; bus.stall = s; bus.branch_taken = b; bus.branch_target = t;
        model_step(r, s, b, t);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 512; i++) mem[i] = rnd_word();
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = $urandom;
        m_pc = 32'hdead_beef; m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0; m_halted = 1'b0; drain_left = 0;
        tick(1'b1, 1'b1, 1'b1, $urandom);
        tick(1'b1, 1'b0, 1'b1, $urandom);
        vectors++;
        if ({bus.pc, bus.ifid_instr, bus.ifid_pc_plus4, bus.ifid_valid, bus.halted} !== {32'd0, 32'd0, 32'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: pc=%h instr=%h pp4=%h valid=%b halted=%b, want all zero",
                     bus.pc, bus.ifid_instr, bus.ifid_pc_plus4, bus.ifid_valid, bus.halted);
        end
    endtask

    task automatic test_seq_fetch();
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'd0);
            vectors++;
            if ({bus.ifid_instr, bus.ifid_pc_plus4, bus.ifid_valid} !== {mem[k-1], 32'(4*k), 1'b1}) begin
                miscompares++;
                $display("FAIL seq_fetch[%0d]: got %h/%h/%b want %h/%h/1", k,
                         bus.ifid_instr, bus.ifid_pc_plus4, bus.ifid_valid, mem[k-1], 32'(4*k));
            end
        end
        vectors++;
        if (bus.pc !== 32'd12) begin
            miscompares++;
            $display("FAIL seq_fetch_pc: got %h want 0000000c", bus.pc);
        end
    endtask

    task automatic test_stall();
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, 1'b1, 1'b0, 32'd0);
            vectors++;
            if ({bus.pc, bus.ifid_instr, bus.ifid_valid} !== {32'd8, mem[1], 1'b1}) begin
                miscompares++;
                $display("FAIL stall[%0d]: got pc=%h instr=%h want pc=8 instr=%h", k, bus.pc, bus.ifid_instr, mem[1]);
            end
        end
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        vectors++;
        if ({bus.ifid_instr, bus.ifid_pc_plus4} !== {mem[2], 32'd12}) begin
            miscompares++;
            $display("FAIL stall_release: got %h/%h want %h/0000000c", bus.ifid_instr, bus.ifid_pc_plus4, mem[2]);
        end
    endtask

    task automatic test_branch_stall();
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        tick(1'b0, 1'b1, 1'b1, 32'h43);
        vectors++;
        if ({bus.pc, bus.ifid_valid, bus.ifid_instr} !== {32'h40, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL branch_stall: got pc=%h valid=%b instr=%h want 40/0/0", bus.pc, bus.ifid_valid, bus.ifid_instr);
        end
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        vectors++;
        if ({bus.ifid_instr, bus.ifid_pc_plus4, bus.ifid_valid} !== {mem[16], 32'h44, 1'b1}) begin
            miscompares++;
            $display("FAIL branch_target_fetch: got %h/%h want %h/00000044", bus.ifid_instr, bus.ifid_pc_plus4, mem[16]);
        end
    endtask

    task automatic test_halt();
        mem[3] = HALT;
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b0, 32'd0);
        vectors++;
        if ({bus.ifid_instr, bus.ifid_pc_plus4, bus.ifid_valid, bus.pc} !== {HALT, 32'd16, 1'b1, 32'd12}) begin
            miscompares++;
            $display("FAIL halt_latch: got %h/%h/%b pc=%h want ffffffff/10/1 pc=c",
                     bus.ifid_instr, bus.ifid_pc_plus4, bus.ifid_valid, bus.pc);
        end
        for (int k = 1; k <= 4; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'd0);
            vectors++;
            if ({bus.ifid_valid, bus.pc, bus.halted} !== {1'b0, 32'd12, (k == 4)}) begin
                miscompares++;
                $display("FAIL halt_drain[%0d]: got valid=%b pc=%h halted=%b want 0/c/%0d", k, bus.ifid_valid, bus.pc, bus.halted, (k == 4));
            end
        end
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, $urandom_range(0, 1), (k % 2 == 0), $urandom_range(0, 2047));
            vectors++;
            if ({bus.halted, bus.pc} !== {1'b1, 32'd12}) begin
                miscompares++;
                $display("FAIL halt_sticky[%0d]: got halted=%b pc=%h want 1/c", k, bus.halted, bus.pc);
            end
        end
        mem[3] = rnd_word();
    endtask

    task automatic test_halt_branch();
        mem[3] = HALT;
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 1'b0, 32'd0);
        tick(1'b0, 1'b0, 1'b1, 32'h20);
        vectors++;
        if ({bus.pc, bus.halted, bus.ifid_valid} !== {32'h20, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL halt_branch: got pc=%h halted=%b valid=%b want 20/0/0", bus.pc, bus.halted, bus.ifid_valid);
        end
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        vectors++;
        if ({bus.ifid_instr, bus.ifid_pc_plus4, bus.ifid_valid} !== {mem[8], 32'h24, 1'b1}) begin
            miscompares++;
            $display("FAIL halt_branch_resume: got %h/%h want %h/00000024", bus.ifid_instr, bus.ifid_pc_plus4, mem[8]);
        end
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'd0);
            vectors++;
            if (dut_vec() !== mdl_vec() || bus.halted !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_branch_run[%0d]: got %h want %h", k, dut_vec(), mdl_vec());
            end
        end
        mem[3] = rnd_word();
    endtask

    task automatic test_halt_reset();
        mem[3] = HALT;
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, 1'b0, 32'd0);
        tick(1'b1, 1'b0, 1'b1, 32'h80);
        vectors++;
        if ({bus.pc, bus.halted, bus.ifid_valid} !== {32'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL drain_reset: got pc=%h halted=%b valid=%b want 0/0/0", bus.pc, bus.halted, bus.ifid_valid);
        end
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        vectors++;
        if ({bus.ifid_instr, bus.ifid_valid} !== {mem[0], 1'b1}) begin
            miscompares++;
            $display("FAIL drain_reset_fetch: got %h want %h", bus.ifid_instr, mem[0]);
        end
        for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 1'b0, 32'd0);
        vectors++;
        if (bus.halted !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_before_reset: got halted=%b want 1", bus.halted);
        end
        tick(1'b1, 1'b1, 1'b1, 32'h80);
        vectors++;
        if ({bus.pc, bus.halted, bus.ifid_valid} !== {32'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL halted_reset: got pc=%h halted=%b valid=%b want 0/0/0", bus.pc, bus.halted, bus.ifid_valid);
        end
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        vectors++;
        if ({bus.ifid_instr, bus.ifid_pc_plus4, bus.ifid_valid} !== {mem[0], 32'd4, 1'b1}) begin
            miscompares++;
            $display("FAIL halted_reset_fetch: got %h/%h want %h/00000004", bus.ifid_instr, bus.ifid_pc_plus4, mem[0]);
        end
        mem[3] = rnd_word();
    endtask

    task automatic test_random();
        logic [31:0] t;
        for (int i = 0; i < 6; i++) mem[$urandom_range(20, 511)] = HALT;
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 600; i++) begin
            t = ($urandom_range(0, 7) == 0) ? (32'hffff_fff0 | 32'($urandom_range(0, 15)))
                                            : 32'($urandom_range(0, 2047));
            tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0), t);
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b1; bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'd0;
        fill_mem();
        test_reset();
        test_seq_fetch();
        test_stall();
        test_branch_stall();
        test_halt();
        test_halt_branch();
        test_halt_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage pipelined CPU. It owns the PC, drives the word address to the combinational instruction RAM, and registers the fetched word into the IF/ID pipeline register consumed by the decode stage. It applies hazard-unit stalls and branch redirects. On fetching the end-of-program word 32'hffffffff it freezes the PC, drains the pipeline, and then raises HALTED for the bench.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
ADDR_W, 9, instruction RAM word-address width (512 words)
HALT_WORD, 32'hffff_ffff, end-of-program instruction encoding
NOP_WORD, 32'h0000_0000, bubble encoding inserted on flush or drain
DRAIN_CYCLES, 4, cycles after the halt word enters IF/ID before HALTED asserts (ID..WB)

Ports:
CLK  in  1  rising-edge clock
RESET  in  1  synchronous, active-high reset
STALL  in  1  hazard hold: keep PC and IF/ID unchanged
BRANCH_TAKEN  in  1  redirect request from the resolving stage
BRANCH_TARGET  in  32  redirect PC; bits [1:0] ignored (forced 0)
IMEM_ADDR  out  ADDR_W  combinational word address = PC[ADDR_W+1:2]
IMEM_DATA  in  32  instruction word at IMEM_ADDR, same cycle
PC  out  32  current fetch PC
IFID_INSTR  out  32  registered instruction for decode
IFID_PC_PLUS4  out  32  registered PC+4 of that instruction
IFID_VALID  out  1  IF/ID holds a real instruction
HALTED  out  1  pipeline drained after the halt word; sticky until RESET

Behaviour:
- Reset: when RESET=1 at a CLK edge: PC<=RESET_PC, IFID_INSTR<=NOP_WORD, IFID_PC_PLUS4<=0, IFID_VALID<=0, HALTED<=0, drain counter<=0, state<=FETCH. RESET overrides every other input in every state, including mid-drain and HALT.
- IMEM_ADDR is purely combinational from PC. There is 0-cycle RAM latency, so an instruction appears in IF/ID 1 cycle after its PC is presented.
- Input priority each edge: RESET > BRANCH_TAKEN > STALL > normal advance.
- State FETCH:
  - BRANCH_TAKEN: PC<={BRANCH_TARGET[31:2],2'b00}; IF/ID<=NOP_WORD with VALID=0 (squash the wrong-path fetch). This applies even when STALL=1.
  - else STALL: PC and all IFID_* hold their values.
  - else IMEM_DATA!=HALT_WORD: IF/ID<={IMEM_DATA, PC+4, VALID=1}; PC<=PC+4. PC+4 wraps modulo 2^32; IMEM_ADDR simply truncates.
  - else (halt word): IF/ID<={HALT_WORD, PC+4, VALID=1}; PC holds; counter<=0; state<=DRAIN.
- State DRAIN: PC frozen; IMEM_DATA ignored.
  - BRANCH_TAKEN: the halt was wrong-path. Redirect the PC as in FETCH, IF/ID<=NOP with VALID=0, counter<=0, state<=FETCH.
  - else STALL: PC, IF/ID and counter all hold.
  - else: IF/ID<=NOP with VALID=0 (on the first advance the halt word moves on to ID); counter<=counter+1. When the counter reaches DRAIN_CYCLES-1, HALTED<=1 and state<=HALT on that edge.
- State HALT: all registers hold; HALTED=1; STALL and BRANCH_TAKEN ignored; only RESET exits.
- The counter width is clog2(DRAIN_CYCLES)+1; it never wraps, because it saturates by leaving DRAIN.
- No combinational path from STALL or BRANCH_* to any output except through registers. IMEM_ADDR depends only on PC.

Test Plan:
- Reset then run, RAM[0..2]=A,B,C: cycle 1 after reset IFID_INSTR=A, IFID_PC_PLUS4=4, VALID=1; cycle 2 B/8; cycle 3 C/12; PC=12.
- STALL held 2 cycles while PC=8: PC stays 8 and IFID_INSTR stays B for both cycles. On release, C/12 appears the next cycle.
- BRANCH_TAKEN with BRANCH_TARGET=32'h43 together with STALL=1 at PC=8: next cycle PC=0x40, IFID_VALID=0, IFID_INSTR=0. The following cycle IFID holds RAM[16] with PC_PLUS4=0x44.
- RAM[3]=32'hffffffff, no stalls: IF/ID shows ffffffff/16, then VALID=0 for 4 edges. PC stays 12 throughout. HALTED rises exactly 4 edges after the halt word is latched and stays 1 over 10 further cycles despite BRANCH_TAKEN pulses.
- Halt fetched, BRANCH_TAKEN to 0x20 on the 2nd drain edge: HALTED never rises, PC=0x20, and fetch resumes with RAM[8] the next cycle.
- RESET asserted on the 3rd drain edge and again while HALTED=1: each time, the next edge gives PC=RESET_PC, HALTED=0, IFID_VALID=0, and normal fetch from address 0 follows.
